// File: rtl/auto_nav_ctrl.sv
// Autonomous maze-car sequencer: MOVE -> decide -> TURN/WAIT phases on a prescaled tick,
// wall-following turn selection, fork/dead-end beacon pulses and a saturating dead-end count.
module auto_nav_ctrl #(
  parameter int TICK_DIV   = 50_000,
  parameter int MOVE_TICKS = 50,
  parameter int TURN_TICKS = 100,
  parameter int WAIT_TICKS = 10,
  parameter int CNT_W      = 8
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       hand_mode,
  input  logic [3:0] turn_detector,
  output logic [1:0] next_state,
  output logic [3:0] next_moving_state,
  output logic       pl_beacon_sig,
  output logic       de_beacon_sig,
  output logic [7:0] dead_end_cnt
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TICKS - 1);

  localparam logic [3:0] DIR_F = 4'b0001;
  localparam logic [3:0] DIR_B = 4'b0010;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_L = 4'b1000;

  typedef enum logic [1:0] {IDLE, MOVE, TURN, WAIT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [3:0]       dir_q, dir_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       ns_q, ns_d;
  logic [3:0]       nms_q, nms_d;
  logic             pl_q, pl_d, de_q, de_d;

  logic       tick;
  logic       open_f, open_r, open_l;
  logic [1:0] n_open;
  logic [3:0] choice;

  assign tick   = (presc_q == PRESC_MAX);
  assign open_f = ~turn_detector[0];
  assign open_r = ~turn_detector[2];
  assign open_l = ~turn_detector[3];
  assign n_open = {1'b0, open_f} + {1'b0, open_r} + {1'b0, open_l};

  // Back is the fallback only when every other way is blocked.
  always_comb begin
    choice = DIR_B;
    if (!hand_mode) begin
      if (open_r)      choice = DIR_R;
      else if (open_f) choice = DIR_F;
      else if (open_l) choice = DIR_L;
    end else begin
      if (open_l)      choice = DIR_L;
      else if (open_f) choice = DIR_F;
      else if (open_r) choice = DIR_R;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pl_d    = 1'b0;
    de_d    = 1'b0;
    presc_d = '0;
    if (enable && state_q != IDLE) presc_d = tick ? '0 : presc_q + 1'b1;

    if (!enable) begin
      state_d = IDLE;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = MOVE;
          phase_d = '0;
          cnt_d   = '0;
        end
        MOVE: if (tick) begin
          if (phase_q == MOVE_LAST) begin
            phase_d = '0;
            dir_d   = choice;
            state_d = (choice == DIR_F) ? WAIT : TURN;
            if (n_open == 2'd0) begin
              de_d = 1'b1;
              if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
            if (n_open >= 2'd2) pl_d = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        TURN: if (tick) begin
          if (phase_q == TURN_LAST) begin
            state_d = WAIT;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        WAIT: if (tick) begin
          if (phase_q == WAIT_LAST) begin
            state_d = MOVE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ns_d  = 2'b00;
    nms_d = 4'b0000;
    case (state_d)
      MOVE:    begin ns_d = 2'b10; nms_d = DIR_F; end
      TURN:    begin ns_d = 2'b01; nms_d = dir_d; end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      phase_q <= '0;
      dir_q   <= '0;
      cnt_q   <= '0;
      ns_q    <= '0;
      nms_q   <= '0;
      pl_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      nms_q   <= nms_d;
      pl_q    <= pl_d;
      de_q    <= de_d;
    end
  end

  assign next_state        = ns_q;
  assign next_moving_state = nms_q;
  assign pl_beacon_sig     = pl_q;
  assign de_beacon_sig     = de_q;
  assign dead_end_cnt      = cnt_q;

endmodule

// File: tb/tb_auto_nav_ctrl.sv
// Directed bench for auto_nav_ctrl with short phases (TICK_DIV=4, MOVE=3, TURN=2, WAIT=1):
// MOVE lasts 12 cycles, TURN 8, WAIT 4. Inputs driven and outputs sampled on the falling edge.
module tb_auto_nav_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, enable, hand_mode;
  logic [3:0] det;
  logic [1:0] ns;
  logic [3:0] nms;
  logic       pl, de;
  logic [7:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  auto_nav_ctrl #(.TICK_DIV(4), .MOVE_TICKS(3), .TURN_TICKS(2), .WAIT_TICKS(1), .CNT_W(8)) dut (
    .sys_clk(clk), .rst(rst_n), .enable(enable), .hand_mode(hand_mode),
    .turn_detector(det), .next_state(ns), .next_moving_state(nms),
    .pl_beacon_sig(pl), .de_beacon_sig(de), .dead_end_cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {next_state, next_moving_state, pl, de} into one comparison.
  task automatic chk_out(input string tag, input logic [1:0] e_ns, input logic [3:0] e_nms,
                         input logic e_pl, input logic e_de);
    chk(tag, {ns, nms, pl, de}, {e_ns, e_nms, e_pl, e_de});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; hand_mode = 1'b0; det = 4'b1111;
    @(negedge clk);
    chk_out("reset_outputs", 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("reset_cnt", cnt, 8'd0);

    rst_n = 1'b1; enable = 1'b1;
    cyc(1);
    chk_out("move_entry", 2'b10, 4'b0001, 1'b0, 1'b0);

    // Fork, right-hand rule: left blocked only -> right
    det = 4'b1000;
    cyc(11);
    chk_out("move_before_decision", 2'b10, 4'b0001, 1'b0, 1'b0);
    cyc(1);
    chk_out("fork_turn_right", 2'b01, 4'b0100, 1'b1, 1'b0);
    det = 4'b1111;
    cyc(1);
    chk_out("pl_one_cycle", 2'b01, 4'b0100, 1'b0, 1'b0);
    cyc(6);
    chk_out("turn_last_cycle", 2'b01, 4'b0100, 1'b0, 1'b0);
    cyc(1);
    chk_out("wait_entry", 2'b00, 4'b0000, 1'b0, 1'b0);
    cyc(3);
    chk_out("wait_last_cycle", 2'b00, 4'b0000, 1'b0, 1'b0);
    cyc(1);
    chk_out("move_again", 2'b10, 4'b0001, 1'b0, 1'b0);

    // Only front open, left-hand rule: straight to WAIT, no pulse
    hand_mode = 1'b1; det = 4'b1100;
    cyc(12);
    chk_out("front_only_wait", 2'b00, 4'b0000, 1'b0, 1'b0);
    cyc(4);
    chk_out("front_only_back_to_move", 2'b10, 4'b0001, 1'b0, 1'b0);

    // Only right open, left-hand rule: turn right without a beacon
    det = 4'b1001;
    cyc(12);
    chk_out("single_right_turn", 2'b01, 4'b0100, 1'b0, 1'b0);
    cyc(12);
    chk_out("single_right_done", 2'b10, 4'b0001, 1'b0, 1'b0);

    // Dead end: f, r, l blocked
    det = 4'b1101;
    cyc(12);
    chk_out("dead_end_turn_back", 2'b01, 4'b0010, 1'b0, 1'b1);
    chk("dead_end_cnt_1", cnt, 8'd1);
    cyc(1);
    chk_out("de_one_cycle", 2'b01, 4'b0010, 1'b0, 1'b0);
    cyc(11);
    for (int i = 2; i <= 300; i++) begin
      cyc(24);
      if (i == 254) chk("dead_end_cnt_254", cnt, 8'd254);
      if (i == 256) chk("dead_end_cnt_sat", cnt, 8'd255);
    end
    chk("dead_end_cnt_300", cnt, 8'd255);
    chk_out("after_dead_ends_move", 2'b10, 4'b0001, 1'b0, 1'b0);

    // All open: hand rule picks right vs left
    det = 4'b0000; hand_mode = 1'b0;
    cyc(12);
    chk_out("all_open_mode0", 2'b01, 4'b0100, 1'b1, 1'b0);
    cyc(12);
    hand_mode = 1'b1;
    cyc(12);
    chk_out("all_open_mode1", 2'b01, 4'b1000, 1'b1, 1'b0);

    // enable drop mid-TURN; dead_end_cnt holds until re-enable
    cyc(2);
    enable = 1'b0;
    cyc(1);
    chk_out("disable_in_turn", 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("cnt_hold_disabled", cnt, 8'd255);
    cyc(3);
    chk_out("idle_stays", 2'b00, 4'b0000, 1'b0, 1'b0);
    enable = 1'b1;
    cyc(1);
    chk_out("reenable_move", 2'b10, 4'b0001, 1'b0, 1'b0);
    chk("cnt_cleared_on_enable", cnt, 8'd0);

    // enable drop on a dead-end decision cycle: no pulse, no count
    det = 4'b1101;
    cyc(11);
    enable = 1'b0;
    cyc(1);
    chk_out("disable_on_decision", 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("disable_on_decision_cnt", cnt, 8'd0);
    enable = 1'b1;
    cyc(1);
    chk_out("reenable_move2", 2'b10, 4'b0001, 1'b0, 1'b0);

    // Async reset mid-MOVE, between clock edges
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 2'b00, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
